// File: rtl/modsub_vec_ctrl_pkg.sv
// Shared constants and state encoding for the vector modular-subtraction sequencer.
package modsub_vec_ctrl_pkg;

  // Latency of the modsub core from i_sub_vld to o_sub_vldout.
  localparam int COMMON_MODSUB_DELAY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/modsub_vec_ctrl_if.sv
// Command and coefficient-RAM bus of the sequencer; master is the sequencer side.
interface modsub_vec_ctrl_if #(
  parameter int MWIDTH = 39,
  parameter int AWIDTH = 10,
  parameter int LWIDTH = 11
);
  logic              i_start;
  logic [LWIDTH-1:0] i_len;
  logic [AWIDTH-1:0] i_base_a;
  logic [AWIDTH-1:0] i_base_b;
  logic [AWIDTH-1:0] i_base_c;
  logic              i_stall;
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [AWIDTH-1:0] o_rd_addr_a;
  logic [AWIDTH-1:0] o_rd_addr_b;
  logic [MWIDTH-1:0] i_rd_data_a;
  logic [MWIDTH-1:0] i_rd_data_b;
  logic              o_wr_en;
  logic [AWIDTH-1:0] o_wr_addr;
  logic [MWIDTH-1:0] o_wr_data;

  modport master (
    input  i_start, i_len, i_base_a, i_base_b, i_base_c, i_stall,
    input  i_rd_data_a, i_rd_data_b,
    output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b,
    output o_wr_en, o_wr_addr, o_wr_data
  );

  modport slave (
    output i_start, i_len, i_base_a, i_base_b, i_base_c, i_stall,
    output i_rd_data_a, i_rd_data_b,
    input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b,
    input  o_wr_en, o_wr_addr, o_wr_data
  );

endinterface

// File: rtl/modsub_vec_ctrl_modsub.sv
// Single-stage modular subtractor: o_sub = (i_a - i_b) mod MOD for operands < MOD.
module modsub #(
  parameter int                MWIDTH = 39,
  parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MWIDTH-1:0] i_a,
  input  logic [MWIDTH-1:0] i_b,
  input  logic              i_sub_vld,
  output logic [MWIDTH-1:0] o_sub,
  output logic              o_sub_vldout
);

  // A borrow out of the extended difference means a < b; adding MOD folds it back into range.
  function automatic logic [MWIDTH-1:0] mod_sub(input logic [MWIDTH-1:0] a,
                                                input logic [MWIDTH-1:0] b);
    logic [MWIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[MWIDTH]) diff = diff + {1'b0, MOD};
    return diff[MWIDTH-1:0];
  endfunction

  logic [MWIDTH-1:0] res_q;
  logic              vld_q;

  // stage p0 -> p1: result register
  always_ff @(posedge clk) begin
    res_q <= mod_sub(i_a, i_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= i_sub_vld;
  end

  assign o_sub        = res_q;
  assign o_sub_vldout = vld_q;

endmodule

// File: rtl/modsub_vec_ctrl.sv
// Sequencer for C[i] = (A[i] - B[i]) mod MOD over a vector held in three RAM banks.
module modsub_vec_ctrl
  import modsub_vec_ctrl_pkg::*;
#(
  parameter int                MWIDTH = 39,
  parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001,
  parameter int                AWIDTH = 10,
  parameter int                LWIDTH = 11,
  parameter int                RD_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  modsub_vec_ctrl_if.master bus
);

  localparam int IFW = $clog2(RD_LAT + 2);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [LWIDTH-1:0] len_q, issued_q, issued_d;
  logic [AWIDTH-1:0] base_a_q, base_b_q;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [IFW-1:0]    inflight_q, inflight_d;
  logic [RD_LAT-1:0] rd_vld_q;
  logic              rd_en, wr_en, last_issue, start_ok;
  logic [MWIDTH-1:0] sub_res;

  assign start_ok   = (state_q == IDLE) && bus.i_start;
  assign rd_en      = (state_q == RUN) && !bus.i_stall && (issued_q < len_q);
  assign last_issue = rd_en && ((issued_q + LWIDTH'(1)) == len_q);

  always_comb begin
    issued_d   = rd_en ? issued_q + LWIDTH'(1) : issued_q;
    wr_addr_d  = wr_en ? wr_addr_q + AWIDTH'(1) : wr_addr_q;
    inflight_d = inflight_q;
    case ({rd_en, wr_en})
      2'b10:   inflight_d = inflight_q + IFW'(1);
      2'b01:   inflight_d = inflight_q - IFW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Drain ends on the cycle the last outstanding result is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.i_start) begin
          if (bus.i_len != '0) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        RUN: if (last_issue) state_q <= DRAIN;
        DRAIN: if (inflight_d == '0) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      wr_addr_q  <= '0;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (start_ok) begin
        len_q     <= bus.i_len;
        issued_q  <= '0;
        base_a_q  <= bus.i_base_a;
        base_b_q  <= bus.i_base_b;
        wr_addr_q <= bus.i_base_c;
      end else begin
        issued_q  <= issued_d;
        wr_addr_q <= wr_addr_d;
      end
    end
  end

  // stage p0 -> p(RD_LAT): read strobe delayed to line up with RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= rd_en;
      for (int k = 1; k < RD_LAT; k++) rd_vld_q[k] <= rd_vld_q[k-1];
    end
  end

  modsub #(
    .MWIDTH (MWIDTH),
    .MOD    (MOD)
  ) u_modsub (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_a          (bus.i_rd_data_a),
    .i_b          (bus.i_rd_data_b),
    .i_sub_vld    (rd_vld_q[RD_LAT-1]),
    .o_sub        (sub_res),
    .o_sub_vldout (wr_en)
  );

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_rd_en     = rd_en;
  assign bus.o_rd_addr_a = base_a_q + issued_q[AWIDTH-1:0];
  assign bus.o_rd_addr_b = base_b_q + issued_q[AWIDTH-1:0];
  assign bus.o_wr_en     = wr_en;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_en ? sub_res : '0;

endmodule

// File: tb/tb_modsub_vec_ctrl.sv
// Directed bench for modsub_vec_ctrl with a one-cycle-latency RAM model.
module tb_modsub_vec_ctrl;

  localparam int          MWIDTH = 39;
  localparam int          AWIDTH = 10;
  localparam int          LWIDTH = 11;
  localparam logic [38:0] MOD    = 39'h40_0080_0001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  modsub_vec_ctrl_if #(.MWIDTH(MWIDTH), .AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) bus();

  modsub_vec_ctrl #(
    .MWIDTH (MWIDTH), .MOD (MOD), .AWIDTH (AWIDTH), .LWIDTH (LWIDTH), .RD_LAT (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [MWIDTH-1:0] mem_a [0:1023];
  logic [MWIDTH-1:0] mem_b [0:1023];

  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      bus.i_rd_data_a <= mem_a[bus.o_rd_addr_a];
      bus.i_rd_data_b <= mem_b[bus.o_rd_addr_b];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_rd_cyc = 0, busy_cnt = 0, stall_viol = 0;
  logic busy_at_done = 1'b0;
  logic [AWIDTH-1:0] rd_a_log[$], wr_addr_log[$];
  logic [MWIDTH-1:0] wr_data_log[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.o_rd_en) begin
      rd_a_log.push_back(bus.o_rd_addr_a);
      last_rd_cyc = cyc;
      if (bus.i_stall) stall_viol++;
    end
    if (bus.o_wr_en) begin
      wr_addr_log.push_back(bus.o_wr_addr);
      wr_data_log.push_back(bus.o_wr_data);
    end
    if (bus.o_busy) busy_cnt++;
    if (bus.o_done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = bus.o_busy;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MWIDTH-1:0] ref_sub(input logic [MWIDTH-1:0] a, input logic [MWIDTH-1:0] b);
    return (a >= b) ? a - b : a + (MOD - b);
  endfunction

  task automatic clr_logs();
    rd_a_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    busy_cnt = 0;
  endtask

  task automatic start_job(input int len, input int ba, input int bb, input int bc);
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_len    = LWIDTH'(len);
    bus.i_base_a = AWIDTH'(ba);
    bus.i_base_b = AWIDTH'(bb);
    bus.i_base_c = AWIDTH'(bc);
    @(posedge clk); #1;
    bus.i_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
    chk(tag, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(bus.o_rd_en), 64'd0);
    chk({tag, "_wr_en"}, 64'(bus.o_wr_en), 64'd0);
    chk({tag, "_busy"},  64'(bus.o_busy), 64'd0);
    chk({tag, "_done"},  64'(bus.o_done), 64'd0);
    chk({tag, "_rd_a"},  64'(bus.o_rd_addr_a), 64'd0);
    chk({tag, "_rd_b"},  64'(bus.o_rd_addr_b), 64'd0);
    chk({tag, "_wr_a"},  64'(bus.o_wr_addr), 64'd0);
    chk({tag, "_wr_d"},  64'(bus.o_wr_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, set_cyc;
    logic [MWIDTH-1:0] exp1 [4];

    bus.i_start = 1'b0; bus.i_len = '0; bus.i_stall = 1'b0;
    bus.i_base_a = '0; bus.i_base_b = '0; bus.i_base_c = '0;
    bus.i_rd_data_a = '0; bus.i_rd_data_b = '0;
    for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_outs_zero("reset");
    rst_n = 1'b1;

    // 1: basic vector with borrow and boundary operands
    mem_a[0] = 39'd10; mem_a[1] = 39'd5; mem_a[2] = 39'd0; mem_a[3] = MOD - 1;
    mem_b[10'h100] = 39'd3; mem_b[10'h101] = 39'd7; mem_b[10'h102] = 39'd1; mem_b[10'h103] = MOD - 1;
    exp1[0] = 39'd7; exp1[1] = 39'h40_007F_FFFF; exp1[2] = 39'h40_0080_0000; exp1[3] = 39'd0;
    clr_logs(); d0 = done_cnt;
    start_job(4, 0, 'h100, 'h200);
    wait_done("t1_timeout", d0, 50);
    repeat (3) @(posedge clk);
    chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t1_done_latency", 64'(done_cyc - last_rd_cyc), 64'd3);
    chk("t1_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("t1_nwr", 64'(wr_addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      chk($sformatf("t1_wr_addr%0d", i), 64'(wr_addr_log[i]), 64'('h200 + i));
      chk($sformatf("t1_wr_data%0d", i), 64'(wr_data_log[i]), 64'(exp1[i]));
    end

    // 2: zero-length job completes without RAM traffic
    clr_logs(); d0 = done_cnt;
    @(posedge clk); #1;
    set_cyc = cyc;
    bus.i_start = 1'b1; bus.i_len = '0;
    @(posedge clk); #1 bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t2_done_cyc", 64'(done_cyc), 64'(set_cyc + 2));
    chk("t2_nrd", 64'(rd_a_log.size()), 64'd0);
    chk("t2_nwr", 64'(wr_addr_log.size()), 64'd0);
    chk("t2_busy", 64'(busy_cnt), 64'd0);

    // 3: stall toggling every cycle
    for (int i = 0; i < 8; i++) begin
      mem_a[10'h10 + i] = MWIDTH'(i * 5);
      mem_b[10'h20 + i] = 39'd7;
    end
    clr_logs(); d0 = done_cnt; stall_viol = 0;
    start_job(8, 'h10, 'h20, 'h30);
    for (int k = 0; k < 300 && done_cnt == d0; k++) begin
      bus.i_stall = ~bus.i_stall;
      @(posedge clk); #1;
    end
    bus.i_stall = 1'b0;
    chk("t3_timeout", 64'(done_cnt != d0), 64'd1);
    repeat (2) @(posedge clk);
    chk("t3_stall_viol", 64'(stall_viol), 64'd0);
    chk("t3_nrd", 64'(rd_a_log.size()), 64'd8);
    chk("t3_nwr", 64'(wr_addr_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
      chk($sformatf("t3_wr_addr%0d", i), 64'(wr_addr_log[i]), 64'('h30 + i));
      chk($sformatf("t3_wr_data%0d", i), 64'(wr_data_log[i]), 64'(ref_sub(MWIDTH'(i * 5), 39'd7)));
    end

    // 4: start during RUN is ignored
    clr_logs(); d0 = done_cnt;
    start_job(4, 0, 'h100, 'h200);
    bus.i_start = 1'b1; bus.i_len = 11'd2;
    bus.i_base_a = 10'h3; bus.i_base_b = 10'h5; bus.i_base_c = 10'h7;
    @(posedge clk); #1 bus.i_start = 1'b0;
    wait_done("t4_timeout", d0, 50);
    repeat (3) @(posedge clk);
    chk("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t4_nwr", 64'(wr_addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      chk($sformatf("t4_wr_addr%0d", i), 64'(wr_addr_log[i]), 64'('h200 + i));
      chk($sformatf("t4_wr_data%0d", i), 64'(wr_data_log[i]), 64'(exp1[i]));
    end

    // 5: asynchronous reset mid-job, then a fresh job
    start_job(16, 0, 'h100, 'h200);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk_outs_zero("t5_async");
    clr_logs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("t5_no_wr", 64'(wr_addr_log.size()), 64'd0);
    chk("t5_no_busy", 64'(busy_cnt), 64'd0);
    clr_logs(); d0 = done_cnt;
    start_job(2, 0, 'h100, 'h200);
    wait_done("t5_timeout", d0, 50);
    repeat (3) @(posedge clk);
    chk("t5_nwr", 64'(wr_addr_log.size()), 64'd2);
    for (int i = 0; i < 2 && i < wr_addr_log.size(); i++) begin
      chk($sformatf("t5_wr_addr%0d", i), 64'(wr_addr_log[i]), 64'('h200 + i));
      chk($sformatf("t5_wr_data%0d", i), 64'(wr_data_log[i]), 64'(exp1[i]));
    end

    // 6: address wrap
    clr_logs(); d0 = done_cnt;
    start_job(4, 'h3FE, 'h050, 'h3FF);
    wait_done("t6_timeout", d0, 50);
    repeat (3) @(posedge clk);
    chk("t6_nrd", 64'(rd_a_log.size()), 64'd4);
    chk("t6_nwr", 64'(wr_addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_a_log.size(); i++)
      chk($sformatf("t6_rd_a%0d", i), 64'(rd_a_log[i]), 64'(10'(10'h3FE + i)));
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++)
      chk($sformatf("t6_wr_addr%0d", i), 64'(wr_addr_log[i]), 64'(10'(10'h3FF + i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
